// File: rtl/vga_term_pkg.sv
// Shared definitions for the text terminal: cell geometry, FSM states, ASCII codes
// and the circular row-index helper.
package vga_term_pkg;

    localparam int CELL_W = 9;
    localparam int CELL_H = 16;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        SCROLL
    } state_t;

    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] BS = 8'h08;
    localparam logic [7:0] SP = 8'h20;

    // (base + off) mod rows using a single conditional subtract; both inputs are < rows
    function automatic logic [4:0] wrap_row(input logic [4:0] base, input logic [4:0] off,
                                            input logic [5:0] rows);
        logic [5:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= rows)
            sum = sum - rows;
        return sum[4:0];
    endfunction

endpackage

// File: rtl/vga_font_rom.sv
// Glyph ROM, 4096 x 8, combinational: addr = {char, py}, bit 7 is the leftmost pixel.
// Glyph table is generated in logic; rows 0, 14, 15 and non-printable codes are blank.
module vga_font_rom (
    input  logic [11:0] addr,
    output logic [7:0]  data
);

    logic [7:0] ch;
    logic [3:0] py;

    assign ch = addr[11:4];
    assign py = addr[3:0];

    always_comb begin
        data = 8'h00;
        if (ch >= 8'h21 && ch <= 8'h7E && py != 4'd0 && py < 4'd14)
            data = ch ^ {py, ~py};
    end

endmodule

// File: rtl/vga_text_term.sv
// Text-mode frame buffer: ASCII byte stream in (valid/ready), RGB888 pixel out, zero latency.
// char_ready is low during CLEAR and SCROLL. Optional blinking underline cursor: VGA_TERM_CURSOR_EN.
module vga_text_term
    import vga_term_pkg::*;
#(
    parameter int          COLS         = 70,
    parameter int          ROWS         = 30,
    parameter logic [23:0] FG_COLOR     = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR     = 24'h000000,
    parameter int          BLINK_CYCLES = 12_500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    input  logic [9:0]  h_addr,
    input  logic [9:0]  v_addr,
    output logic [23:0] vga_data,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row
);

    localparam int          CELLS     = COLS * ROWS;
    localparam logic [11:0] LAST_CELL = 12'(CELLS - 1);
    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
    localparam logic [5:0]  ROWS6     = 6'(ROWS);
    localparam logic [9:0]  TEXT_W    = 10'(COLS * CELL_W);

    state_t      state;
    logic [6:0]  col, scroll_cnt;
    logic [4:0]  row, top_row;
    logic [11:0] clr_addr;
    logic [7:0]  ram [CELLS];

    logic        accept, printable, newline;
    logic        we;
    logic [11:0] waddr, cur_base;
    logic [7:0]  wdat;

    function automatic logic [11:0] row_base(input logic [4:0] phys);
        return 12'(phys) * 12'(COLS);
    endfunction

    assign char_ready = (state == IDLE);
    assign accept     = char_valid && char_ready;
    assign printable  = (char_data >= 8'h20) && (char_data <= 8'h7E);
    assign newline    = (char_data == LF) || (printable && col == LAST_COL);
    assign cur_base   = row_base(wrap_row(top_row, row, ROWS6));
    assign cursor_col = col;
    assign cursor_row = row;

    always_comb begin
        we    = 1'b0;
        waddr = clr_addr;
        wdat  = SP;
        case (state)
            CLEAR: we = 1'b1;
            SCROLL: begin
                // top_row has already advanced, so the last logical row is the stale one
                we    = 1'b1;
                waddr = row_base(wrap_row(top_row, LAST_ROW, ROWS6)) + 12'(scroll_cnt);
            end
            IDLE: begin
                if (accept && printable) begin
                    we    = 1'b1;
                    waddr = cur_base + 12'(col);
                    wdat  = char_data;
                end else if (accept && char_data == BS && col != 7'd0) begin
                    we    = 1'b1;
                    waddr = cur_base + 12'(col - 7'd1);
                end
            end
            default: we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we)
            ram[waddr] <= wdat;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= CLEAR;
            clr_addr   <= 12'd0;
            scroll_cnt <= 7'd0;
            col        <= 7'd0;
            row        <= 5'd0;
            top_row    <= 5'd0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_addr == LAST_CELL) begin
                        clr_addr <= 12'd0;
                        state    <= IDLE;
                    end else begin
                        clr_addr <= clr_addr + 12'd1;
                    end
                end
                SCROLL: begin
                    if (scroll_cnt == LAST_COL) begin
                        scroll_cnt <= 7'd0;
                        state      <= IDLE;
                    end else begin
                        scroll_cnt <= scroll_cnt + 7'd1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        if (printable && col != LAST_COL)
                            col <= col + 7'd1;
                        else if (newline || char_data == CR)
                            col <= 7'd0;
                        else if (char_data == BS && col != 7'd0)
                            col <= col - 7'd1;
                        if (newline) begin
                            if (row != LAST_ROW) begin
                                row <= row + 5'd1;
                            end else begin
                                top_row <= wrap_row(top_row, 5'd1, ROWS6);
                                state   <= SCROLL;
                            end
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    logic [9:0]  ccol, px;
    logic [4:0]  crow;
    logic [3:0]  py;
    logic        in_text, pix_on, cursor_hit;
    logic [11:0] rd_addr;
    logic [7:0]  cell_ch, glyph;
    logic        unused_bits;

    assign ccol        = h_addr / 10'(CELL_W);
    assign px          = h_addr - ccol * 10'(CELL_W);
    assign crow        = v_addr[8:4];
    assign py          = v_addr[3:0];
    assign in_text     = (h_addr < TEXT_W) && ({1'b0, crow} < ROWS6);
    assign rd_addr     = in_text ? row_base(wrap_row(top_row, crow, ROWS6)) + 12'(ccol[6:0]) : 12'd0;
    assign cell_ch     = ram[rd_addr];
    assign unused_bits = ^{v_addr[9], ccol[9:7]};

    vga_font_rom u_font (
        .addr ({cell_ch, py}),
        .data (glyph)
    );

    assign pix_on = in_text && (px != 10'd8) && glyph[3'd7 - px[2:0]];

`ifdef VGA_TERM_CURSOR_EN
    logic [31:0] blink_cnt;
    logic        blink;

    always_ff @(posedge clk) begin
        if (!rst) begin
            blink_cnt <= 32'd0;
            blink     <= 1'b0;
        end else if (blink_cnt == 32'(BLINK_CYCLES - 1)) begin
            blink_cnt <= 32'd0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + 32'd1;
        end
    end

    assign cursor_hit = blink && in_text && (ccol[6:0] == col) && (crow == row) && (py >= 4'd14);
`else
    localparam int unused_blink = BLINK_CYCLES;
    assign cursor_hit = 1'b0;
`endif

    assign vga_data = (pix_on || cursor_hit) ? FG_COLOR : BG_COLOR;

endmodule

// File: tb/tb_vga_text_term.sv
// Bench for vga_text_term: byte-stream table, hand-written clear/scroll/reset sequences and a
// random byte stream, all checked against a logical-screen model of the terminal.
module tb_vga_text_term;

    localparam int          COLS  = 70;
    localparam int          ROWS  = 30;
    localparam logic [23:0] FG    = 24'hFFFFFF;
    localparam logic [23:0] BG    = 24'h000000;
    localparam int          BLINK = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready;
    logic [9:0]  h_addr = 10'd0;
    logic [9:0]  v_addr = 10'd0;
    logic [23:0] vga_data;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;

    vga_text_term #(
        .COLS(COLS), .ROWS(ROWS), .FG_COLOR(FG), .BG_COLOR(BG), .BLINK_CYCLES(BLINK)
    ) dut (
        .clk(clk), .rst(rst), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready), .h_addr(h_addr), .v_addr(v_addr), .vga_data(vga_data),
        .cursor_col(cursor_col), .cursor_row(cursor_row)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // logical screen: row 0 is always the top displayed row
    logic [7:0] scr [ROWS][COLS];
    int mc = 0, mr = 0;
    int n_since_rst = 0;

    always @(posedge clk) begin
        if (!rst) n_since_rst <= 0;
        else      n_since_rst <= n_since_rst + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] font_model(input logic [7:0] c, input int py);
        int v;
        if (c < 33 || c > 126 || py == 0 || py >= 14) return 8'h00;
        v = (int'(c) ^ ((py << 4) | (15 - py))) & 255;
        return 8'(v);
    endfunction

    function automatic logic [23:0] exp_pix(input int h, input int v);
        int cc, pxx, cr, pyy;
        logic [7:0] g;
        if (h >= COLS * 9 || v >= ROWS * 16) return BG;
        cc = h / 9; pxx = h % 9; cr = v / 16; pyy = v % 16;
`ifdef VGA_TERM_CURSOR_EN
        if (((n_since_rst / BLINK) % 2) == 1 && cc == mc && cr == mr && pyy >= 14) return FG;
`endif
        if (pxx == 8) return BG;
        g = font_model(scr[cr][cc], pyy);
        return g[7 - pxx] ? FG : BG;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = 8'h20;
        mc = 0; mr = 0;
    endtask

    task automatic model_newline(output bit scrolled);
        scrolled = 0;
        mc = 0;
        if (mr < ROWS - 1) begin
            mr++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++) scr[r] = scr[r + 1];
            for (int c = 0; c < COLS; c++) scr[ROWS - 1][c] = 8'h20;
            scrolled = 1;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, output bit scrolled);
        scrolled = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[mr][mc] = b;
            if (mc == COLS - 1) model_newline(scrolled);
            else mc++;
        end else if (b == 8'h0A) begin
            model_newline(scrolled);
        end else if (b == 8'h0D) begin
            mc = 0;
        end else if (b == 8'h08 && mc > 0) begin
            mc--;
            scr[mr][mc] = 8'h20;
        end
    endtask

    task automatic pix(input int h, input int v, input string name);
        @(negedge clk);
        h_addr = 10'(h); v_addr = 10'(v);
        #1;
        chk(name, 32'(vga_data), 32'(exp_pix(h, v)));
    endtask

    task automatic check_cell(input int cc, input int cr);
        for (int py = 0; py < 16; py++)
            for (int px = 0; px < 9; px++)
                pix(cc * 9 + px, cr * 16 + py, "cell_pixel");
    endtask

    task automatic check_screen_sample();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                pix(c * 9 + $urandom_range(0, 8), r * 16 + $urandom_range(0, 15), "screen_pixel");
    endtask

    task automatic count_low(input int exp, input string name);
        int cnt = 0;
        while (!char_ready && cnt < 5000) begin
            cnt++;
            @(negedge clk);
        end
        chk(name, 32'(cnt), 32'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(char_ready), 32'd0);
        chk("rst_col", 32'(cursor_col), 32'd0);
        chk("rst_row", 32'(cursor_row), 32'd0);
        model_reset();
        rst = 1'b1;
        count_low(2100, "clear_cycles");
    endtask

    task automatic send(input logic [7:0] b);
        int w = 0;
        bit scrolled;
        @(negedge clk);
        while (!char_ready && w < 3000) begin
            w++;
            @(negedge clk);
        end
        if (!char_ready) begin
            chk("ready_timeout", 32'(char_ready), 32'd1);
            return;
        end
        char_valid = 1'b1; char_data = b;
        @(posedge clk);
        #1;
        char_valid = 1'b0; char_data = 8'($urandom);
        model_byte(b, scrolled);
        if (scrolled) begin
            @(negedge clk);
            count_low(70, "scroll_cycles");
        end
        chk("cursor_col", 32'(cursor_col), 32'(mc));
        chk("cursor_row", 32'(cursor_row), 32'(mr));
    endtask

    typedef struct {
        logic [7:0] ch;
        int         col;
        int         row;
    } vec_t;

    vec_t tbl [12];
    logic [7:0] b;
    int r;

    initial begin
        tbl[0]  = '{8'h0D, 0, 0};   // CR after 'A'
        tbl[1]  = '{8'h08, 0, 0};   // BS at column 0: no-op
        tbl[2]  = '{8'h48, 1, 0};
        tbl[3]  = '{8'h45, 2, 0};
        tbl[4]  = '{8'h4C, 3, 0};
        tbl[5]  = '{8'h4C, 4, 0};
        tbl[6]  = '{8'h4F, 5, 0};
        tbl[7]  = '{8'h08, 4, 0};   // BS at column 5
        tbl[8]  = '{8'h01, 4, 0};   // dropped
        tbl[9]  = '{8'h7F, 4, 0};   // dropped
        tbl[10] = '{8'h0A, 0, 1};
        tbl[11] = '{8'h7E, 1, 1};

        do_reset();
        check_screen_sample();

        send(8'h41);
        chk("A_col", 32'(cursor_col), 32'd1);
        chk("A_row", 32'(cursor_row), 32'd0);
        check_cell(0, 0);
        @(negedge clk);
        h_addr = 10'd8; v_addr = 10'd5;
        #1;
        chk("A_gap_bg", 32'(vga_data), 32'(BG));

        for (int i = 0; i < 12; i++) begin
            send(tbl[i].ch);
            chk("tbl_col", 32'(cursor_col), 32'(tbl[i].col));
            chk("tbl_row", 32'(cursor_row), 32'(tbl[i].row));
        end
        check_cell(4, 0);
        check_cell(0, 0);

        send(8'h0D);
        for (int i = 0; i < 70; i++) send(8'h42);
        chk("wrap_col", 32'(cursor_col), 32'd0);
        chk("wrap_row", 32'(cursor_row), 32'd2);
        check_cell(69, 1);

        while (mr < ROWS - 1) send(8'h0A);
        send(8'h0A);
        chk("scroll_row", 32'(cursor_row), 32'd29);
        check_cell(0, 0);
        check_cell(69, 0);
        for (int c = 0; c < COLS; c++) pix(c * 9 + 3, 29 * 16 + 7, "bottom_blank");
        check_screen_sample();

        // reset in the middle of a scroll
        @(negedge clk);
        char_valid = 1'b1; char_data = 8'h0A;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_scroll_ready", 32'(char_ready), 32'd0);
        do_reset();
        check_screen_sample();
        send(8'h5A);
        check_cell(0, 0);

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 62)      b = 8'($urandom_range(32, 126));
            else if (r < 72) b = 8'h0A;
            else if (r < 77) b = 8'h0D;
            else if (r < 87) b = 8'h08;
            else begin
                b = 8'($urandom_range(0, 255));
                if ((b >= 8'h20 && b <= 8'h7E) || b == 8'h0A || b == 8'h0D || b == 8'h08) b = 8'h01;
            end
            send(b);
        end
        check_screen_sample();
        for (int i = 0; i < 300; i++)
            pix(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), "rand_pixel");
        pix(629, 20, "edge_629");
        pix(630, 20, "edge_630");
        pix(639, 479, "edge_639");

`ifdef VGA_TERM_CURSOR_EN
        for (int i = 0; i < 40; i++) begin
            pix(mc * 9 + 2, mr * 16 + 15, "cursor_blink_15");
            pix(mc * 9 + 8, mr * 16 + 14, "cursor_blink_14");
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
